// File: rtl/leaf_router.sv
// leaf_router: 5-port leaf router (ports 0-3 are NI leaves, port 4 is the uplink).
// Each input has a FIFO. The head flit is routed by its header: group [15:12]
// equal to GROUP_ID selects leaf [11:10], any other group goes to the uplink.
// Foreign-group flits arriving on the uplink are dropped. Each output has an
// independent round-robin arbiter and a registered output stage.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high
//   in_data    - 5 x DATA_W input flits, slice p = port p
//   in_valid   - per-port input valid
//   in_ready   - per-port FIFO not full
//   out_data   - 5 x DATA_W registered output flits
//   out_valid  - per-port registered output valid
//   out_ready  - per-port downstream ready
//   drop_count - (only with LEAF_ROUTER_STATS_EN) saturating 8-bit count of
//                uplink drops
//
// Build option: define LEAF_ROUTER_STATS_EN to add the drop_count port.
// FIFO_DEPTH must be a power of two, at least 2. DATA_W must be at least 16.
module leaf_router #(
    parameter int unsigned GROUP_ID   = 1,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5*DATA_W-1:0] in_data,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    output logic [5*DATA_W-1:0] out_data,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready
`ifdef LEAF_ROUTER_STATS_EN
    ,
    output logic [7:0]          drop_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // FIFO storage and state
    logic [DATA_W-1:0] mem_q      [5][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q   [5];
    logic [PTR_W-1:0]  rd_ptr_q   [5];
    logic [CNT_W-1:0]  count_q    [5];

    // Output stage and arbiter state
    logic [2:0]        rr_q       [5];
    logic [DATA_W-1:0] out_data_q [5];
    logic [4:0]        out_valid_q;

    // Combinational routing / arbitration
    logic [DATA_W-1:0] head       [5];
    logic [2:0]        dest       [5];
    logic [4:0]        nonempty;
    logic [4:0]        drop;
    logic [4:0]        push;
    logic [4:0]        pop;
    logic [4:0]        load;
    logic [4:0]        gnt_any;
    logic [2:0]        gnt_idx    [5];

    always_comb begin
        for (int unsigned i = 0; i < 5; i++) begin
            head[i]     = mem_q[i][rd_ptr_q[i]];
            nonempty[i] = (count_q[i] != '0);
            in_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            push[i]     = in_valid[i] && in_ready[i];
            if (head[i][15:12] == 4'(GROUP_ID)) begin
                dest[i] = {1'b0, head[i][11:10]};
            end else begin
                dest[i] = 3'd4;
            end
            // Foreign traffic coming down the uplink has nowhere to go.
            drop[i] = (i == 4) && nonempty[i] && (head[i][15:12] != 4'(GROUP_ID));
        end
    end

    // Round-robin per output, searching upward from rr_q[o]. An input requests
    // exactly one output, so it can never win two grants in the same cycle.
    always_comb begin
        int unsigned c;
        c   = 0;
        pop = drop;
        for (int unsigned o = 0; o < 5; o++) begin
            load[o]    = !out_valid_q[o] || out_ready[o];
            gnt_any[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int unsigned k = 0; k < 5; k++) begin
                c = {29'b0, rr_q[o]} + k;
                if (c >= 5) begin
                    c = c - 5;
                end
                if (load[o] && !gnt_any[o] && nonempty[c] && !drop[c] &&
                    (dest[c] == 3'(o))) begin
                    gnt_any[o] = 1'b1;
                    gnt_idx[o] = c[2:0];
                end
            end
            if (gnt_any[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    // FIFO storage is not reset; emptiness is tracked by count/pointers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 5; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 5; i++) begin
                wr_ptr_q[i]   <= '0;
                rd_ptr_q[i]   <= '0;
                count_q[i]    <= '0;
                rr_q[i]       <= '0;
                out_data_q[i] <= '0;
            end
            out_valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                // Pointers wrap naturally because FIFO_DEPTH is a power of two.
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count_q[i] <= count_q[i] + CNT_W'(1);
                end else if (pop[i] && !push[i]) begin
                    count_q[i] <= count_q[i] - CNT_W'(1);
                end
            end
            for (int unsigned o = 0; o < 5; o++) begin
                if (load[o]) begin
                    out_valid_q[o] <= gnt_any[o];
                    if (gnt_any[o]) begin
                        out_data_q[o] <= head[gnt_idx[o]];
                        rr_q[o]       <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < 5; o++) begin
            out_data[o*DATA_W +: DATA_W] = out_data_q[o];
        end
        out_valid = out_valid_q;
    end

`ifdef LEAF_ROUTER_STATS_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop[4] && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
